// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack handshake into an instruction
// register, presents it to the decoders and computes the next PC at retire.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    input  logic             stall,
    input  logic             branch,
    input  logic             ne,
    input  logic             jump,
    input  logic             zero,
    output logic [31:0]      instr,
    output logic [5:0]       op,
    output logic             instr_valid,
    output logic [31:0]      pc,
    output logic [31:0]      pcplus4,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic {
        FETCH = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t           state_reg;
    logic [31:0]      pc_reg;
    logic [31:0]      instr_reg;
    logic [CNT_W-1:0] retired_reg;

    logic [31:0] pc_next;
    logic [31:0] br_offset;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic        take_branch;

    // Branch offset is sext(imm16) << 2, built bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_br_offset
            if (gi < 2) begin : g_low
                assign br_offset[gi] = 1'b0;
            end else if (gi < 18) begin : g_imm
                assign br_offset[gi] = instr_reg[gi-2];
            end else begin : g_sext
                assign br_offset[gi] = instr_reg[15];
            end
        end
    endgenerate

    assign pcplus4       = pc_reg + 32'd4;
    assign jump_target   = {pcplus4[31:28], instr_reg[25:0], 2'b00};
    assign branch_target = pcplus4 + br_offset;
    assign take_branch   = branch & (zero ^ ne);

    // Jump outranks branch when the decoder raises both.
    always_comb begin
        pc_next = pcplus4;
        if (jump) begin
            pc_next = jump_target;
        end else if (take_branch) begin
            pc_next = branch_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= FETCH;
            pc_reg      <= RESET_PC;
            instr_reg   <= 32'd0;
            retired_reg <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (imem_ack) begin
                        instr_reg <= imem_rdata;
                        state_reg <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall) begin
                        pc_reg      <= pc_next;
                        retired_reg <= retired_reg + {{(CNT_W-1){1'b0}}, 1'b1};
                        state_reg   <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    // The request drops during reset so an in-flight fetch is abandoned at once.
    assign imem_req    = (state_reg == FETCH) & ~reset;
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == ISSUE);
    assign instr       = instr_reg;
    assign op          = instr_reg[31:26];
    assign pc          = pc_reg;
    assign retired     = retired_reg;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios then randomized fetch/retire
// traffic, checked against a PC/retire-count model built from MIPS next-PC rules.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch;
    logic        ne;
    logic        jump;
    logic        zero;
    logic [31:0] instr;
    logic [5:0]  op;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pcplus4;
    logic [31:0] retired;

    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_retired;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch(branch), .ne(ne), .jump(jump), .zero(zero),
        .instr(instr), .op(op), .instr_valid(instr_valid),
        .pc(pc), .pcplus4(pcplus4), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ctrl();
        branch = 1'($urandom);
        ne     = 1'($urandom);
        jump   = 1'($urandom);
        zero   = 1'($urandom);
    endtask

    function automatic logic [31:0] model_next(input logic [31:0] cur_pc, input logic [31:0] word,
                                               input logic b, input logic n, input logic j,
                                               input logic z);
        logic [31:0] seq;
        int          off;
        seq = cur_pc + 32'd4;
        if (j) return (seq & 32'hF000_0000) | ({6'd0, word[25:0]} * 32'd4);
        if (b && (z != n)) begin
            off = $signed(word[15:0]);
            return seq + 32'(off * 4);
        end
        return seq;
    endfunction

    task automatic model_reset();
        m_pc      = 32'h0000_0000;
        m_instr   = 32'h0000_0000;
        m_retired = 32'd0;
    endtask

    task automatic fetch(input logic [31:0] word, input int lat);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, m_pc);
        chk("fetch_ivalid", {31'd0, instr_valid}, 32'd0);
        repeat (lat) begin
            rand_ctrl();
            stall = 1'($urandom);
            tick();
            chk("addr_hold", imem_addr, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        tick();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        m_instr    = word;
        chk("issue_ivalid", {31'd0, instr_valid}, 32'd1);
        chk("issue_instr", instr, m_instr);
        chk("issue_op", {26'd0, op}, {26'd0, m_instr[31:26]});
        chk("issue_pc", pc, m_pc);
        chk("issue_pcplus4", pcplus4, m_pc + 32'd4);
        chk("issue_req", {31'd0, imem_req}, 32'd0);
    endtask

    task automatic retire(input logic b, input logic n, input logic j, input logic z,
                          input int nstall);
        logic [31:0] exp_next;
        repeat (nstall) begin
            stall = 1'b1;
            rand_ctrl();
            tick();
            chk("stall_pc", pc, m_pc);
            chk("stall_instr", instr, m_instr);
            chk("stall_retired", retired, m_retired);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_ivalid", {31'd0, instr_valid}, 32'd1);
        end
        stall  = 1'b0;
        branch = b;
        ne     = n;
        jump   = j;
        zero   = z;
        exp_next = model_next(m_pc, m_instr, b, n, j, z);
        tick();
        m_pc      = exp_next;
        m_retired = m_retired + 32'd1;
        chk("next_addr", imem_addr, m_pc);
        chk("retired", retired, m_retired);
        chk("retire_ivalid", {31'd0, instr_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'd0; stall = 1'b0;
        branch = 1'b0; ne = 1'b0; jump = 1'b0; zero = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd1);
        chk("rst_addr", imem_addr, 32'h0);

        // Addi with 3-cycle memory latency, then sequential retire.
        fetch(32'h2008_0005, 3);
        chk("addi_op", {26'd0, op}, 32'h08);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("seq_addr", imem_addr, 32'h4);
        chk("seq_retired", retired, 32'd1);

        fetch($urandom, 1);
        retire(1'b0, 1'b1, 1'b0, 1'b1, 0);
        // beq taken from 0x8.
        fetch(32'h1000_0003, 0);
        retire(1'b1, 1'b0, 1'b0, 1'b1, 0);
        chk("beq_target", imem_addr, 32'h18);
        // Jump back to 0x8, then bne with zero=1 falls through.
        fetch(32'h0800_0002, 2);
        retire(1'b0, 1'b0, 1'b1, 1'b0, 0);
        fetch(32'h1000_0003, 0);
        retire(1'b1, 1'b1, 1'b0, 1'b1, 0);
        chk("bne_fallthru", imem_addr, 32'hC);
        fetch(32'h0800_0008, 1);
        retire(1'b0, 1'b0, 1'b1, 1'b0, 0);
        chk("jump_0x20", imem_addr, 32'h20);
        // Jump wins over a taken branch.
        fetch(32'h0800_0010, 0);
        retire(1'b1, 1'b0, 1'b1, 1'b1, 0);
        chk("jump_prio", imem_addr, 32'h40);
        // Four stall cycles then advance.
        fetch($urandom, 1);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 4);
        chk("post_stall", imem_addr, 32'h44);
        // Backward branch wraps below zero to the top word.
        fetch(32'h1000_FFED, 0);
        retire(1'b1, 1'b0, 1'b0, 1'b1, 0);
        chk("branch_wrap", imem_addr, 32'hFFFF_FFFC);
        fetch($urandom, 2);
        chk("top_pcplus4", pcplus4, 32'h0);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 0);
        chk("seq_wrap", imem_addr, 32'h0);

        // Reset while stalled in ISSUE.
        fetch($urandom, 0);
        stall = 1'b1;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        stall = 1'b0;
        model_reset();
        #1;
        chk("rst_stall_retired", retired, 32'd0);
        chk("rst_stall_ivalid", {31'd0, instr_valid}, 32'd0);
        chk("rst_stall_instr", instr, 32'd0);
        chk("rst_stall_addr", imem_addr, 32'h0);

        for (int i = 0; i < 150; i++) begin
            fetch($urandom, int'($urandom_range(0, 3)));
            retire(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom),
                   int'($urandom_range(0, 2)));
        end

        // Reset mid-fetch with an ack racing the reset: data must be dropped.
        tick();
        reset      = 1'b1;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        #1;
        chk("rst_fetch_req", {31'd0, imem_req}, 32'd0);
        tick();
        reset    = 1'b0;
        imem_ack = 1'b0;
        model_reset();
        #1;
        chk("rst_fetch_addr", imem_addr, 32'h0);
        chk("rst_fetch_req2", {31'd0, imem_req}, 32'd1);
        chk("rst_fetch_instr", instr, 32'd0);
        chk("rst_fetch_ivalid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("rst_fetch_instr2", instr, 32'd0);
        chk("rst_fetch_ivalid2", {31'd0, instr_valid}, 32'd0);
        fetch(32'h2008_0005, 1);
        retire(1'b0, 1'b0, 1'b0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
